sync_fifo: RTL and testbench
============================

# sync_fifo

Single-clock synchronous FIFO that serves as the design under test behind the team's FIFO interface. A write-side agent drives `wr_en`/`data_in`. A read-side agent drives `rd_en` and samples `data_out`/`full`/`empty`. All outputs are registered. Overflow and underflow attempts are absorbed harmlessly and flagged, so the monitor can check them.

## Interface
- `FIFO_WIDTH`, default 32: data word width in bits.
- `FIFO_DEPTH`, default 32 (2**5): number of entries. Must be a power of two and at least 2.
- `AW`, derived: `$clog2(FIFO_DEPTH)`. Not user-overridable.

Ports:
- `clk`  input  1  single clock; all state changes on the rising edge.
- `rstN`  input  1  reset, synchronous, active-low.
- `wr_en`  input  1  write request.
- `data_in`  input  FIFO_WIDTH  write data, sampled with `wr_en`.
- `rd_en`  input  1  read request.
- `data_out`  output  FIFO_WIDTH  read data, registered.
- `empty`  output  1  FIFO holds 0 entries.
- `full`  output  1  FIFO holds FIFO_DEPTH entries.
- `count`  output  AW+1  current occupancy, 0..FIFO_DEPTH.
- `overflow`  output  1  one-cycle pulse: write requested while full.
- `underflow`  output  1  one-cycle pulse: read requested while empty.

## Operation
- Storage: array of FIFO_DEPTH words of FIFO_WIDTH bits. Memory contents are not reset.
- Pointers:
  - `wr_ptr` and `rd_ptr` are AW+1 bits wide. The MSB is the wrap bit.
  - The low AW bits index memory.
  - Each pointer increments modulo 2^(AW+1).
- Accept rules, evaluated on registered flags at the edge:
  - Write accepted when `wr_en && !full`. Then `mem[wr_ptr[AW-1:0]] <= data_in` and `wr_ptr` increments.
  - Read accepted when `rd_en && !empty`. Then `data_out <= mem[rd_ptr[AW-1:0]]` and `rd_ptr` increments.
- Rejected requests:
  - A rejected write changes no state except `overflow`.
  - A rejected read leaves `data_out` unchanged and changes no state except `underflow`.
- Count update:
  - `count` +1 on accepted write only.
  - `count` −1 on accepted read only.
  - `count` unchanged when both or neither are accepted.
- Flags, registered and derived from the next-state pointers:
  - `empty` = (next_wr_ptr == next_rd_ptr).
  - `full` = (MSBs differ) && (low AW bits equal).
- Simultaneous `wr_en`+`rd_en`:
  - Neither full nor empty: both accepted; count and flags unchanged.
  - Empty: only the write is accepted; `underflow` pulses; `empty` deasserts next cycle.
  - Full: only the read is accepted; `overflow` pulses; `full` deasserts next cycle.
- No read-through on empty: a word written in cycle N is readable no earlier than the edge of cycle N+1.
- `data_out` holds the last read word until the next accepted read.
- Reset:
  - When `rstN`=0 at an edge, `wr_ptr`, `rd_ptr` and `count` go to 0.
  - `empty`=1, `full`=0, `data_out`=0, `overflow`=0, `underflow`=0.
  - Reset overrides any concurrent `wr_en`/`rd_en`.
  - Reset mid-operation discards all stored entries.

## Timing
- Inputs are sampled at posedge `clk`. The verification agents drive and sample with 2 ns skew relative to the edge, so RTL paths must meet that margin.
- Write-to-flag latency:
  - `empty` falls, `count` increments and `full` rises at the same edge that accepts the write.
  - They are visible after that edge.
- Read latency: 1 edge. `data_out` is valid after the edge that accepts `rd_en`, and the flags update at the same edge.
- `overflow`/`underflow` assert for exactly one cycle after the offending edge. Sustained requests pulse on every offending edge.
- Minimum write-to-read turnaround: a write at edge N can be read at edge N+1, giving `data_out` after N+1.
- Throughput: one write and one read per cycle sustained when not at a boundary.

## Test plan
- Reset: hold `rstN`=0 for 3 cycles with `wr_en`=`rd_en`=1 → `empty`=1, `full`=0, `count`=0, `data_out`=0, no pulses.
- Fill and drain: write 0x0..0x1F on 32 consecutive cycles.
  - After the 32nd write, `full`=1 and `count`=32.
  - Then read 32 cycles: `data_out` = 0x0..0x1F in order, and `empty`=1 after the last read.
- Overflow: when full, write 0xDEADBEEF → `overflow` pulses for 1 cycle, `count` stays 32, and the next 32 reads contain no 0xDEADBEEF.
- Underflow: when empty, assert `rd_en` for 2 cycles → `underflow` pulses twice and `data_out` holds its prior value.
- Simultaneous boundary cases:
  - Empty with wr+rd of 0xA5 → `count`=1 and `underflow`=1; the next read returns 0xA5.
  - Full with wr+rd → `count`=31, `overflow`=1, and the oldest word is returned.
- Wrap-around and mid-op reset:
  - Stream 100 words with `wr_en`/`rd_en` both high after 5 prefill words → order preserved and `count` stays 5.
  - Then `rstN`=0 for 1 cycle → `empty`=1 and `count`=0; subsequent write/read of 0x1234 returns 0x1234.

Source files
------------

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered data_out, flags and occupancy count.
// Over/underflow attempts are dropped and reported as one-cycle pulses.
module sync_fifo #(
  parameter int FIFO_WIDTH = 32,
  parameter int FIFO_DEPTH = 32,
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  wr_en,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  full,
  output logic [AW:0]           count,
  output logic                  overflow,
  output logic                  underflow
);

  logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic [FIFO_WIDTH-1:0] data_q;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;
  logic                  ovf_q, unf_q;
  logic                  wr_acc, rd_acc;

  assign wr_acc = wr_en && !full_q;
  assign rd_acc = rd_en && !empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(wr_acc);
    rd_ptr_d = rd_ptr_q + (AW+1)'(rd_acc);
    count_d  = count_q + (AW+1)'(wr_acc)
             - (AW+1)'(rd_acc);
    empty_d  = (wr_ptr_d == rd_ptr_d);
    full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW])
            && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (rstN && wr_acc) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      ovf_q    <= wr_en && full_q;
      unf_q    <= rd_en && empty_q;
      if (rd_acc) begin
        data_q <= mem_q[rd_ptr_q[AW-1:0]];
      end
    end
  end

  assign data_out  = data_q;
  assign empty     = empty_q;
  assign full      = full_q;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: reset, fill/drain, boundary
// accept rules, wrap-around streaming and mid-operation reset.
module tb_sync_fifo;

  logic        clk = 1'b0;
  logic        rstN;
  logic        wr_en;
  logic [31:0] data_in;
  logic        rd_en;
  logic [31:0] data_out;
  logic        empty;
  logic        full;
  logic [5:0]  count;
  logic        overflow;
  logic        underflow;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sync_fifo #(.FIFO_WIDTH(32), .FIFO_DEPTH(32)) dut (
    .clk(clk), .rstN(rstN),
    .wr_en(wr_en), .data_in(data_in),
    .rd_en(rd_en), .data_out(data_out),
    .empty(empty), .full(full), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstN = 1'b0; wr_en = 1'b1; rd_en = 1'b1;
    data_in = 32'hFFFF_FFFF;
    repeat (3) tick();
    n_cmp++;
    if (empty !== 1'b1) begin
      n_fail++; $display("FAIL reset_empty got %0b exp 1", empty);
    end
    n_cmp++;
    if (full !== 1'b0) begin
      n_fail++; $display("FAIL reset_full got %0b exp 0", full);
    end
    n_cmp++;
    if (count !== 6'd0) begin
      n_fail++; $display("FAIL reset_count got %0d exp 0", count);
    end
    n_cmp++;
    if (data_out !== 32'h0) begin
      n_fail++; $display("FAIL reset_dout got %h exp 0", data_out);
    end
    n_cmp++;
    if ({overflow, underflow} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_pulses got %b exp 00", {overflow, underflow});
    end
    rstN = 1'b1; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
    tick();
  endtask

  task automatic test_fill_overflow_drain();
    for (int i = 0; i < 32; i++) begin
      wr_en = 1'b1; data_in = i;
      tick();
      n_cmp++;
      if (count !== 6'(i + 1)) begin
        n_fail++;
        $display("FAIL fill_count got %0d exp %0d", count, i + 1);
      end
    end
    wr_en = 1'b0;
    n_cmp++;
    if (full !== 1'b1) begin
      n_fail++; $display("FAIL fill_full got %0b exp 1", full);
    end
    wr_en = 1'b1; data_in = 32'hDEAD_BEEF;
    tick();
    wr_en = 1'b0;
    n_cmp++;
    if (overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_pulse got %0b exp 1", overflow);
    end
    n_cmp++;
    if (count !== 6'd32) begin
      n_fail++; $display("FAIL ovf_count got %0d exp 32", count);
    end
    tick();
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_fail++; $display("FAIL ovf_clear got %0b exp 0", overflow);
    end
    for (int i = 0; i < 32; i++) begin
      rd_en = 1'b1;
      tick();
      n_cmp++;
      if (data_out !== 32'(i)) begin
        n_fail++;
        $display("FAIL drain_data got %h exp %h", data_out, 32'(i));
      end
    end
    rd_en = 1'b0;
    n_cmp++;
    if (empty !== 1'b1 || count !== 6'd0) begin
      n_fail++;
      $display("FAIL drain_empty got e=%0b c=%0d exp e=1 c=0",
               empty, count);
    end
  endtask

  task automatic test_underflow();
    for (int i = 0; i < 2; i++) begin
      rd_en = 1'b1;
      tick();
      n_cmp++;
      if (underflow !== 1'b1) begin
        n_fail++; $display("FAIL unf_pulse got %0b exp 1", underflow);
      end
      n_cmp++;
      if (data_out !== 32'h1F) begin
        n_fail++; $display("FAIL unf_hold got %h exp 1f", data_out);
      end
    end
    rd_en = 1'b0;
    tick();
    n_cmp++;
    if (underflow !== 1'b0) begin
      n_fail++; $display("FAIL unf_clear got %0b exp 0", underflow);
    end
  endtask

  task automatic test_simul_empty();
    wr_en = 1'b1; rd_en = 1'b1; data_in = 32'hA5;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    n_cmp++;
    if (count !== 6'd1 || underflow !== 1'b1 || empty !== 1'b0) begin
      n_fail++;
      $display("FAIL se_state got c=%0d u=%0b e=%0b exp c=1 u=1 e=0",
               count, underflow, empty);
    end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    n_cmp++;
    if (data_out !== 32'hA5 || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL se_read got d=%h e=%0b exp d=a5 e=1",
               data_out, empty);
    end
  endtask

  task automatic test_simul_full();
    for (int i = 0; i < 32; i++) begin
      wr_en = 1'b1; data_in = 32'h100 + i;
      tick();
    end
    n_cmp++;
    if (full !== 1'b1) begin
      n_fail++; $display("FAIL sf_full got %0b exp 1", full);
    end
    wr_en = 1'b1; rd_en = 1'b1; data_in = 32'h777;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    n_cmp++;
    if (count !== 6'd31 || overflow !== 1'b1 || full !== 1'b0) begin
      n_fail++;
      $display("FAIL sf_state got c=%0d o=%0b f=%0b exp c=31 o=1 f=0",
               count, overflow, full);
    end
    n_cmp++;
    if (data_out !== 32'h100) begin
      n_fail++; $display("FAIL sf_oldest got %h exp 100", data_out);
    end
    for (int i = 1; i < 32; i++) begin
      rd_en = 1'b1;
      tick();
      n_cmp++;
      if (data_out !== 32'h100 + i) begin
        n_fail++;
        $display("FAIL sf_drain got %h exp %h",
                 data_out, 32'h100 + i);
      end
    end
    rd_en = 1'b0;
    n_cmp++;
    if (empty !== 1'b1) begin
      n_fail++; $display("FAIL sf_empty got %0b exp 1", empty);
    end
  endtask

  task automatic test_wrap_and_reset();
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; data_in = 32'h2000 + i;
      tick();
    end
    for (int k = 0; k < 100; k++) begin
      wr_en = 1'b1; rd_en = 1'b1; data_in = 32'h2005 + k;
      tick();
      n_cmp++;
      if (data_out !== 32'h2000 + k || count !== 6'd5) begin
        n_fail++;
        $display("FAIL wrap got d=%h c=%0d exp d=%h c=5",
                 data_out, count, 32'h2000 + k);
      end
    end
    wr_en = 1'b0; rd_en = 1'b0;
    rstN = 1'b0;
    tick();
    rstN = 1'b1;
    n_cmp++;
    if (empty !== 1'b1 || count !== 6'd0 || data_out !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_rst got e=%0b c=%0d d=%h exp e=1 c=0 d=0",
               empty, count, data_out);
    end
    wr_en = 1'b1; data_in = 32'h1234;
    tick();
    wr_en = 1'b0;
    n_cmp++;
    if (count !== 6'd1) begin
      n_fail++; $display("FAIL post_rst_count got %0d exp 1", count);
    end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    n_cmp++;
    if (data_out !== 32'h1234 || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL post_rst_read got d=%h e=%0b exp d=1234 e=1",
               data_out, empty);
    end
  endtask

  initial begin
    rstN = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
    test_reset();
    test_fill_overflow_drain();
    test_underflow();
    test_simul_empty();
    test_simul_full();
    test_wrap_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
